// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_ent_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry FIFO of {inst, pc} pairs with combinational head.
// clear outranks push; a push on a full FIFO is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_ent_t    push_ent,
    input  logic          pop,
    output fetch_ent_t    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    fetch_ent_t    mem_reg [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            always_ff @(posedge clk) begin
                if (push_ok && !clear && (wr_ptr_reg == AW'(gi)))
                    mem_reg[gi] <= push_ent;
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_top.sv
// Instruction-fetch stage: PC, credit-limited requests, tag queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module fetch_top
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_dat,
    input  logic        bubble,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_reg;
    logic [CW-1:0] inflight_reg;   // all outstanding requests, live and to-be-dropped
    logic [CW-1:0] drop_reg;
    logic [31:0]   tag_reg [DEPTH];
    logic [AW-1:0] tag_wr_reg;
    logic [AW-1:0] tag_rd_reg;

    logic          credit;
    logic          hs;
    logic          rsp_live;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    fetch_ent_t    fifo_head;
    fetch_ent_t    push_ent;

    assign credit        = ({1'b0, inflight_reg} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);
    // A redirect withdraws this cycle's request so memory never sees a stale address.
    assign imem_req_vld  = ~rst & ~ex_redirect & credit;
    assign imem_req_addr = pc_reg;
    assign hs            = imem_req_vld & imem_req_rdy;
    assign rsp_live      = imem_rsp_vld & ~ex_redirect & (drop_reg == '0);
    assign fifo_pop      = ~bubble & ~fifo_empty & ~ex_redirect;
    assign push_ent      = '{inst: imem_rsp_dat, pc: tag_reg[tag_rd_reg]};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (ex_redirect),
        .push     (rsp_live),
        .push_ent (push_ent),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
            tag_wr_reg   <= '0;
            tag_rd_reg   <= '0;
        end else if (ex_redirect) begin
            pc_reg       <= word_align(ex_redirect_pc);
            inflight_reg <= inflight_reg - CW'(imem_rsp_vld);
            drop_reg     <= inflight_reg - CW'(imem_rsp_vld);
            tag_wr_reg   <= '0;
            tag_rd_reg   <= '0;
        end else begin
            if (hs) pc_reg <= pc_reg + 32'd4;
            inflight_reg <= inflight_reg + CW'(hs) - CW'(imem_rsp_vld);
            if (imem_rsp_vld && (drop_reg != '0)) drop_reg <= drop_reg - CW'(1);
            if (hs)       tag_wr_reg <= tag_wr_reg + AW'(1);
            if (rsp_live) tag_rd_reg <= tag_rd_reg + AW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (hs && (tag_wr_reg == AW'(gi)))
                    tag_reg[gi] <= pc_reg;
            end
        end
    endgenerate

    assign if_inst = fifo_empty ? NOP_INST : fifo_head.inst;
    assign if_pc   = fifo_empty ? 32'h0    : fifo_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (fifo_pop && (perf_fetched_reg != '1))
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if ((fifo_empty || bubble) && (perf_stall_reg != '1))
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

    rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_vld |-> (inflight_reg != '0));
    no_push_on_full: assert property (@(posedge clk) disable iff (rst)
        !(rsp_live && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: cycle table, directed corner sequences and a
// randomized run against a queue-based model of memory and the fetch buffer.
module tb_fetch_top;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_dat;
    logic        bubble;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_top #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_vld   (imem_req_vld),
        .imem_req_rdy   (imem_req_rdy),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_vld   (imem_rsp_vld),
        .imem_rsp_dat   (imem_rsp_dat),
        .bubble         (bubble),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          drop;
    } mreq_t;

    typedef struct {
        bit          bub;
        bit          vld;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    mreq_t       memq[$];   // requests accepted by memory, oldest first
    logic [31:0] bufq[$];   // PCs of words waiting for decode, oldest first
    logic [31:0] req_pc;
    int          cyc;
    int          checks;
    int          errors;
    int          lat_min;
    int          lat_max;
    bit          rsp_en;
    bit          verbose;
    int          hs_count;
    int          n_fetched;
    int          n_stall;
    logic        obs_vld;
    logic [31:0] obs_addr;
    logic [31:0] obs_inst;
    logic [31:0] obs_pc;
    vec_t        tbl[15];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_rdy   = 1'b0;
        imem_rsp_vld   = 1'b0;
        imem_rsp_dat   = 32'h0;
        bubble         = 1'b0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_req_vld", {31'b0, imem_req_vld}, 32'h0);
        check32("reset_if_inst", if_inst, NOP_INST);
        check32("reset_if_pc", if_pc, 32'h0);
        rst = 1'b0;
        memq.delete();
        bufq.delete();
        req_pc    = RESET_PC;
        cyc       = 0;
        hs_count  = 0;
        n_fetched = 0;
        n_stall   = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input bit bub, input bit rdy_i, input bit redir, input logic [31:0] tgt);
        bit          rsp;
        bit          hs;
        bit          exp_vld;
        mreq_t       rsp_ent;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        bubble         = bub;
        imem_req_rdy   = rdy_i;
        ex_redirect    = redir;
        ex_redirect_pc = tgt;
        rsp            = rsp_en && (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_vld   = rsp;
        imem_rsp_dat   = rsp ? mem_data(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_vld  = !redir && ((memq.size() + bufq.size()) < DEPTH);
        exp_inst = (bufq.size() > 0) ? mem_data(bufq[0]) : NOP_INST;
        exp_pc   = (bufq.size() > 0) ? bufq[0] : 32'h0;
        check32("model_req_vld", {31'b0, imem_req_vld}, {31'b0, exp_vld});
        check32("model_req_addr", imem_req_addr, req_pc);
        check32("model_if_inst", if_inst, exp_inst);
        check32("model_if_pc", if_pc, exp_pc);
        obs_vld  = imem_req_vld;
        obs_addr = imem_req_addr;
        obs_inst = if_inst;
        obs_pc   = if_pc;
        hs       = imem_req_vld & rdy_i;
        if (verbose)
            $display("cyc=%0d req=%0b addr=%h rsp=%0b redir=%0b bub=%0b if_inst=%h if_pc=%h",
                     cyc, hs, imem_req_addr, rsp, redir, bub, if_inst, if_pc);
        if ((bufq.size() == 0) || bub) n_stall++;
        if ((bufq.size() > 0) && !bub && !redir) n_fetched++;
        if (rsp) rsp_ent = memq.pop_front();
        if (redir) begin
            bufq.delete();
            foreach (memq[i]) memq[i].drop = 1'b1;
            req_pc = word_align(tgt);
        end else begin
            if ((bufq.size() > 0) && !bub) void'(bufq.pop_front());
            if (rsp && !rsp_ent.drop) bufq.push_back(rsp_ent.addr);
            if (hs) begin
                memq.push_back('{addr: req_pc, due: cyc + $urandom_range(lat_max, lat_min), drop: 1'b0});
                req_pc = req_pc + 32'd4;
                hs_count++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check32("perf_fetched", perf_fetched, n_fetched);
        check32("perf_stall", perf_stall, n_stall);
`endif
    endtask

    initial begin
        bit found;
        checks  = 0;
        errors  = 0;
        verbose = 1'b1;
        rst_init: begin
            rst = 1'b1;
        end

        // {bubble, req_vld, req_addr, if_inst, if_pc}: latency 1, mem[i]=i, 3-cycle bubble
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  NOP_INST, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'd4,  NOP_INST, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'd8,  32'd0,    32'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'd12, 32'd1,    32'd4};
        tbl[4]  = '{1'b0, 1'b1, 32'd16, 32'd2,    32'd8};
        tbl[5]  = '{1'b0, 1'b1, 32'd20, 32'd3,    32'd12};
        tbl[6]  = '{1'b1, 1'b1, 32'd24, 32'd4,    32'd16};
        tbl[7]  = '{1'b1, 1'b1, 32'd28, 32'd4,    32'd16};
        tbl[8]  = '{1'b1, 1'b0, 32'd32, 32'd4,    32'd16};
        tbl[9]  = '{1'b0, 1'b0, 32'd32, 32'd4,    32'd16};
        tbl[10] = '{1'b0, 1'b1, 32'd32, 32'd5,    32'd20};
        tbl[11] = '{1'b0, 1'b1, 32'd36, 32'd6,    32'd24};
        tbl[12] = '{1'b0, 1'b1, 32'd40, 32'd7,    32'd28};
        tbl[13] = '{1'b0, 1'b1, 32'd44, 32'd8,    32'd32};
        tbl[14] = '{1'b0, 1'b1, 32'd48, 32'd9,    32'd36};

        rsp_en  = 1'b1;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].bub, 1'b1, 1'b0, 32'h0);
            check32($sformatf("tbl%0d_req_vld", i), {31'b0, obs_vld}, {31'b0, tbl[i].vld});
            check32($sformatf("tbl%0d_req_addr", i), obs_addr, tbl[i].addr);
            check32($sformatf("tbl%0d_if_inst", i), obs_inst, tbl[i].inst);
            check32($sformatf("tbl%0d_if_pc", i), obs_pc, tbl[i].pc);
        end
        check_perf();

        // Redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("redir_next_addr", obs_addr, 32'h100);
        check32("redir_next_inst", obs_inst, NOP_INST);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (obs_inst !== NOP_INST) found = 1'b1;
        end
        check32("redir_target_seen", {31'b0, found}, 32'h1);
        check32("redir_target_pc", obs_pc, 32'h100);
        check32("redir_target_inst", obs_inst, mem_data(32'h100));

        // Responses withheld: credits run out after DEPTH handshakes
        lat_min = 1;
        lat_max = 1;
        do_reset();
        rsp_en = 1'b0;
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("credit_hs_count", hs_count, DEPTH);
        check32("credit_vld_low", {31'b0, obs_vld}, 32'h0);
        rsp_en = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (obs_vld === 1'b1) found = 1'b1;
        end
        check32("credit_returns", {31'b0, found}, 32'h1);

        // Redirect coinciding with a response and a bubble on a valid head
        lat_min = 2;
        lat_max = 2;
        do_reset();
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("combo_rsp_present", {31'b0, memq.size() > 0 && memq[0].due <= cyc}, 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        check32("combo_head_valid", obs_inst, mem_data(32'h0));
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("combo_nop_after", obs_inst, NOP_INST);
        repeat (15) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_perf();

        // PC wrap and misaligned redirect target
        lat_min = 1;
        lat_max = 1;
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("wrap_addr0", obs_addr, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("wrap_addr1", obs_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("wrap_addr2", obs_addr, 32'h0000_0000);
        cycle(1'b0, 1'b1, 1'b1, 32'h8000_0103);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("misalign_addr", obs_addr, 32'h8000_0100);
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic against the model
        verbose = 1'b0;
        lat_min = 1;
        lat_max = 4;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rsp_en = ($urandom_range(4, 0) != 0);
            cycle(($urandom_range(3, 0) == 0), ($urandom_range(3, 0) != 0),
                  ($urandom_range(39, 0) == 0), $urandom);
        end
        check_perf();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
